alu_seq_unit: RTL and testbench

//   Parametrised, registered successor to the combinational ALU. Keeps the 6-bit opcode map.

---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/opcode request channel and result/flag response channel of the sequential ALU.
// The unit owns the slave modport; the issuing stage owns the master modport.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [5:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             ZF;
  logic             CF;
  logic             NF;
  logic             OF;
  logic             DZ;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, result_hi, ZF, CF, NF, OF, DZ
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, result_hi, ZF, CF, NF, OF, DZ
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready handshakes, iterative shift-add MUL and restoring DIV/MOD.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV/MOD.
// Backpressure: one op in flight; outputs held while out_valid && !out_ready, in_ready only in IDLE.
module alu_seq_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  typedef struct packed {
    logic zf;
    logic cf;
    logic nf;
    logic of;
    logic dz;
  } flags_t;

  localparam int              M        = WIDTH - 1;
  localparam logic [5:0]      OP_ADD   = 6'h09;
  localparam logic [5:0]      OP_SUB   = 6'h0A;
  localparam logic [5:0]      OP_SHR   = 6'h0B;
  localparam logic [5:0]      OP_SHL   = 6'h0C;
  localparam logic [5:0]      OP_ROR   = 6'h0D;
  localparam logic [5:0]      OP_ROL   = 6'h0E;
  localparam logic [5:0]      OP_MOV   = 6'h0F;
  localparam logic [5:0]      OP_MUL   = 6'h10;
  localparam logic [5:0]      OP_DIV   = 6'h11;
  localparam logic [5:0]      OP_MOD   = 6'h12;
  localparam logic [5:0]      OP_AND   = 6'h13;
  localparam logic [5:0]      OP_OR    = 6'h14;
  localparam logic [5:0]      OP_XOR   = 6'h15;
  localparam logic [5:0]      OP_NEG   = 6'h16;
  localparam logic [5:0]      OP_CMP   = 6'h17;
  localparam logic [5:0]      OP_TST   = 6'h18;
  localparam logic [5:0]      OP_INC   = 6'h19;
  localparam logic [5:0]      OP_DEC   = 6'h1A;
  localparam logic [WIDTH-1:0] WVAL     = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  flags_t           flags_q;

  // ---------------- single-cycle datapath (operates on the live bus operands) ----------------
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] sub_dif;
  logic [WIDTH-1:0] shr_m1;
  logic [WIDTH-1:0] shl_m1;
  logic [WIDTH-1:0] ror_res;
  logic [WIDTH-1:0] rol_res;
  logic [WIDTH-1:0] and_res;
  logic [SHW-1:0]   s;
  logic [SHW:0]     inv_s;
  logic             b_in_range;
  logic             b_big;
  logic             add_of;
  logic             sub_of;
  logic [WIDTH-1:0] sc_res;
  flags_t           sc_fl;
  logic             auto_zn;

  assign add_sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign inc_sum    = {1'b0, bus.a} + {1'b0, ONE};
  assign sub_dif    = bus.a - bus.b;
  assign shr_m1     = bus.a >> (bus.b - ONE);
  assign shl_m1     = bus.a << (bus.b - ONE);
  assign s          = bus.b[SHW-1:0];
  assign inv_s      = (SHW+1)'(WIDTH) - {1'b0, s};
  assign ror_res    = (bus.a >> s) | (bus.a << inv_s);
  assign rol_res    = (bus.a << s) | (bus.a >> inv_s);
  assign and_res    = bus.a & bus.b;
  assign b_in_range = (bus.b != '0) && (bus.b <= WVAL);
  assign b_big      = (bus.b >= WVAL);
  assign add_of     = (bus.a[M] == bus.b[M]) && (add_sum[M] != bus.a[M]);
  assign sub_of     = (bus.a[M] != bus.b[M]) && (sub_dif[M] != bus.a[M]);

  always_comb begin
    sc_res  = '0;
    sc_fl   = '0;
    auto_zn = 1'b1;
    case (bus.opcode)
      OP_ADD: begin sc_res = add_sum[M:0]; sc_fl.cf = add_sum[WIDTH]; sc_fl.of = add_of; end
      OP_SUB: begin sc_res = sub_dif; sc_fl.cf = (bus.a < bus.b); sc_fl.of = sub_of; end
      OP_SHR: begin
        sc_res   = b_big ? '0 : (bus.a >> bus.b);
        sc_fl.cf = b_in_range & shr_m1[0];
      end
      OP_SHL: begin
        sc_res   = b_big ? '0 : (bus.a << bus.b);
        sc_fl.cf = b_in_range & shl_m1[M];
      end
      // The last bit rotated out lands in the MSB (ROR) or LSB (ROL) of the result.
      OP_ROR: begin sc_res = ror_res; sc_fl.cf = (s != '0) & ror_res[M]; end
      OP_ROL: begin sc_res = rol_res; sc_fl.cf = (s != '0) & rol_res[0]; end
      OP_MOV: sc_res = bus.a;
      OP_AND: sc_res = and_res;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_XOR: sc_res = bus.a ^ bus.b;
      OP_NEG: begin sc_res = (~bus.a) + ONE; sc_fl.of = (bus.a == MSB_ONLY); end
      OP_CMP: begin
        auto_zn  = 1'b0;
        sc_fl.cf = (bus.a < bus.b);
        sc_fl.of = sub_of;
        sc_fl.nf = sub_dif[M];
        sc_fl.zf = (bus.a == bus.b);
      end
      OP_TST: begin
        auto_zn  = 1'b0;
        sc_fl.zf = (and_res == '0);
        sc_fl.nf = and_res[M];
      end
      OP_INC: begin sc_res = inc_sum[M:0]; sc_fl.cf = inc_sum[WIDTH]; end
      OP_DEC: begin sc_res = bus.a - ONE; sc_fl.cf = (bus.a == '0); end
      default: auto_zn = 1'b0;
    endcase
    if (auto_zn) begin
      sc_fl.zf = (sc_res == '0);
      sc_fl.nf = sc_res[M];
    end
  end

  // ---------------- iterative datapath: {hi,lo} is product, or {remainder,quotient} ----------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_ok;
  logic             div_zero;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH-1:0] fin_hi;
  flags_t           fin_fl;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
  assign div_shift = {hi, lo[M]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opb};
  assign div_ok    = ~div_trial[WIDTH+1];
  assign div_zero  = (opb == '0);
  assign step_hi   = (op_q == OP_MUL) ? mul_sum[WIDTH:1]
                   : (div_ok ? div_trial[M:0] : div_shift[M:0]);
  assign step_lo   = (op_q == OP_MUL) ? {mul_sum[0], lo[M:1]} : {lo[M-1:0], div_ok};

  always_comb begin
    fin_res = '0;
    fin_hi  = '0;
    fin_fl  = '0;
    case (op_q)
      OP_MUL: begin
        fin_res   = step_lo;
        fin_hi    = step_hi;
        fin_fl.cf = (step_hi != '0);
        fin_fl.of = (step_hi != '0);
      end
      OP_DIV: begin fin_res = div_zero ? '1 : step_lo; fin_fl.dz = div_zero; end
      default: begin fin_res = div_zero ? opa : step_hi; fin_fl.dz = div_zero; end
    endcase
    fin_fl.zf = (fin_res == '0);
    fin_fl.nf = fin_res[M];
  end

  // ---------------- control FSM with registered outputs ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      opa         <= '0;
      opb         <= '0;
      hi          <= '0;
      lo          <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.opcode;
            opa        <= bus.a;
            opb        <= bus.b;
            in_ready_q <= 1'b0;
            if (bus.opcode == OP_MUL || bus.opcode == OP_DIV || bus.opcode == OP_MOD) begin
              hi    <= '0;
              lo    <= (bus.opcode == OP_MUL) ? bus.b : bus.a;
              cnt   <= '0;
              state <= S_EXEC;
            end else begin
              result_q    <= sc_res;
              result_hi_q <= '0;
              flags_q     <= sc_fl;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + SHW'(1);
          if (cnt == CNT_LAST) begin
            result_q    <= fin_res;
            result_hi_q <= fin_hi;
            flags_q     <= fin_fl;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.ZF        = flags_q.zf;
  assign bus.CF        = flags_q.cf;
  assign bus.NF        = flags_q.nf;
  assign bus.OF        = flags_q.of;
  assign bus.DZ        = flags_q.dz;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed vector table, reset/abort sequences, and random ops vs a reference model.
module tb_alu_seq_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq_unit #(.WIDTH(16), .SHW(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Flags are compared as {ZF,CF,NF,OF,DZ}.
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic [4:0]  fl;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {bus.ZF, bus.CF, bus.NF, bus.OF, bus.DZ};
  endfunction

  // Reference model straight from the opcode rules, using plain integer arithmetic.
  function automatic void model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [15:0] h,
                                output logic [4:0] fl, output int lat);
    int ua, ub, sa, sb, t;
    longint p;
    logic [15:0] rot;
    bit z, c, n, o, d, gen;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = '0; h = '0; z = 0; c = 0; n = 0; o = 0; d = 0; gen = 1; lat = 1;
    case (op)
      6'h09: begin t = ua + ub; r = 16'(t); c = (t > 65535);
                   o = (sa + sb > 32767) || (sa + sb < -32768); end
      6'h0A: begin t = ua - ub; r = 16'(t); c = (ua < ub);
                   o = (sa - sb > 32767) || (sa - sb < -32768); end
      6'h0B: begin r = (ub < 16) ? 16'(ua >> ub) : 16'h0;
                   c = (ub >= 1 && ub <= 16) && (((ua >> (ub - 1)) & 1) != 0); end
      6'h0C: begin r = (ub < 16) ? 16'(ua << ub) : 16'h0;
                   c = (ub >= 1 && ub <= 16) && (((ua >> (16 - ub)) & 1) != 0); end
      6'h0D, 6'h0E: begin
        rot = a;
        for (int i = 0; i < ub % 16; i++) begin
          if (op == 6'h0D) begin c = rot[0];  rot = {rot[0], rot[15:1]}; end
          else             begin c = rot[15]; rot = {rot[14:0], rot[15]}; end
        end
        r = rot;
      end
      6'h0F: r = a;
      6'h10: begin p = longint'(ua) * longint'(ub); r = 16'(p); h = 16'(p >> 16);
                   c = (h != 0); o = c; lat = 17; end
      6'h11: begin lat = 17; if (ub == 0) begin r = 16'hFFFF; d = 1; end else r = 16'(ua / ub); end
      6'h12: begin lat = 17; if (ub == 0) begin r = a; d = 1; end else r = 16'(ua % ub); end
      6'h13: r = a & b;
      6'h14: r = a | b;
      6'h15: r = a ^ b;
      6'h16: begin r = 16'(-ua); o = (sa == -32768); end
      6'h17: begin gen = 0; c = (ua < ub); o = (sa - sb > 32767) || (sa - sb < -32768);
                   t = ua - ub; n = t[15]; z = (ua == ub); end
      6'h18: begin gen = 0; t = ua & ub; z = (t == 0); n = t[15]; end
      6'h19: begin t = ua + 1; r = 16'(t); c = (t > 65535); end
      6'h1A: begin t = ua - 1; r = 16'(t); c = (ua == 0); end
      default: gen = 0;
    endcase
    if (gen) begin z = (r == 0); n = r[15]; end
    fl = {z, c, n, o, d};
  endfunction

  // Issue one op, measure accept->out_valid latency, check outputs, hold backpressure, retire.
  task automatic run_op(input string name, input logic [5:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic [15:0] eh,
                        input logic [4:0] ef, input int elat, input int hold);
    int lat;
    bit busy;
    @(negedge clk);
    check({name, "/in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.opcode = op; bus.a = a; bus.b = b; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.opcode = 6'($urandom);
    lat = 1; busy = 0;
    while (!bus.out_valid && lat < 40) begin
      busy |= bus.in_ready;
      @(negedge clk);
      lat++;
    end
    check({name, "/latency"}, lat, elat);
    check({name, "/in_ready_busy"}, {busy, bus.in_ready}, 0);
    check({name, "/result"}, bus.result, er);
    check({name, "/result_hi"}, bus.result_hi, eh);
    check({name, "/flags"}, flags_now(), ef);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "/hold"}, {bus.out_valid, bus.in_ready, bus.result, flags_now()},
            {1'b1, 1'b0, er, ef});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, "/retire"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0]  op;
    logic [15:0] ra, rb, er, eh;
    logic [4:0]  ef;
    int          elat, pick;
    bit          seen;

    vecs[0]  = '{"add_ovf",  6'h09, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b00110, 1,  0};
    vecs[1]  = '{"sub",      6'h0A, 16'h0011, 16'h0002, 16'h000F, 16'h0000, 5'b00000, 1,  0};
    vecs[2]  = '{"sub_brw",  6'h0A, 16'h0002, 16'h0011, 16'hFFF1, 16'h0000, 5'b01100, 1,  1};
    vecs[3]  = '{"mul",      6'h10, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b01010, 17, 5};
    vecs[4]  = '{"div",      6'h11, 16'd100,  16'd7,    16'd14,   16'h0000, 5'b00000, 17, 0};
    vecs[5]  = '{"mod",      6'h12, 16'd100,  16'd7,    16'd2,    16'h0000, 5'b00000, 17, 0};
    vecs[6]  = '{"div_z",    6'h11, 16'h1234, 16'h0000, 16'hFFFF, 16'h0000, 5'b00101, 17, 0};
    vecs[7]  = '{"mod_z",    6'h12, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 5'b00001, 17, 0};
    vecs[8]  = '{"rol",      6'h0E, 16'h8001, 16'h0011, 16'h0003, 16'h0000, 5'b01000, 1,  0};
    vecs[9]  = '{"shr_16",   6'h0B, 16'h0011, 16'h0010, 16'h0000, 16'h0000, 5'b10000, 1,  0};
    vecs[10] = '{"neg_min",  6'h16, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 5'b00110, 1,  0};
    vecs[11] = '{"cmp_eq",   6'h17, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 5'b10000, 1,  0};
    vecs[12] = '{"tst",      6'h18, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0000, 5'b10000, 1,  0};
    vecs[13] = '{"inc_wrap", 6'h19, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 5'b11000, 1,  0};
    vecs[14] = '{"dec_wrap", 6'h1A, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 5'b01100, 1,  0};
    vecs[15] = '{"bad_op",   6'h3F, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b00000, 1,  2};
    vecs[16] = '{"shl_16",   6'h0C, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 5'b11000, 1,  0};
    vecs[17] = '{"ror",      6'h0D, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 5'b01100, 1,  0};
    vecs[18] = '{"mul_max",  6'h10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b01010, 17, 0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.opcode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {bus.in_ready, bus.out_valid, bus.result, bus.result_hi, flags_now()},
          {1'b1, 1'b0, 16'h0, 16'h0, 5'b0});
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].hi,
             vecs[i].fl, vecs[i].lat, vecs[i].hold);

    // Reset during MUL EXEC aborts the op: no out_valid, everything back to reset values.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = 6'h10; bus.a = 16'h1234; bus.b = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort/exec_busy", {bus.in_ready, bus.out_valid}, 2'b00);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort/state", {bus.in_ready, bus.out_valid, bus.result, bus.result_hi, flags_now()},
          {1'b1, 1'b0, 16'h0, 16'h0, 5'b0});
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= bus.out_valid; end
    check("abort/no_valid", seen, 0);

    // Reset while held in DONE also drops the pending result.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = 6'h0F; bus.a = 16'hBEEF; bus.b = 16'h0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("done_rst/valid", {bus.out_valid, bus.result}, {1'b1, 16'hBEEF});
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("done_rst/state", {bus.in_ready, bus.out_valid, bus.result}, {1'b1, 1'b0, 16'h0});

    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 19);
      op = (pick < 18) ? 6'(6'h09 + pick) : 6'($urandom_range(0, 63));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 16'($urandom_range(0, 1)) << 15;
      model(op, ra, rb, er, eh, ef, elat);
      run_op($sformatf("rnd%0d_op%02h", i, op), op, ra, rb, er, eh, ef, elat, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
